// File: rtl/fetch_queue_pnpc.sv
// fetch_queue_pnpc
//   Instruction-fetch stage: PC/nPC register pair, a big-endian byte-addressed
//   instruction ROM, and a QDEPTH-entry prefetch queue. The queue drives the
//   IF/ID register through a valid/ready handshake. The stage also handles
//   stall back-pressure, redirect-with-flush, and address wrap-around.
//   Optional feature macro: ALIGN_CHECK_EN. When it is defined, a sticky
//   misalign_err flag is set by any redirect to a non-word-aligned target.
//   ROM contents (Mem) are loaded from outside the design.
module fetch_queue_pnpc #(
    parameter int          ADDR_W   = 9,
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        misalign_err
);

    localparam int              PW       = $clog2(QDEPTH);
    localparam int              CW       = PW + 1;
    localparam int              MEMSZ    = 1 << ADDR_W;
    localparam logic [CW-1:0]   FULL_CNT = CW'(QDEPTH);

    // Instruction ROM, one byte per location
    logic [7:0]        Mem [0:MEMSZ-1];

    // Architectural fetch pointers
    logic [31:0]       r_pc;
    logic [31:0]       r_npc;

    // Prefetch queue storage and bookkeeping
    logic [31:0]       r_q_pc    [0:QDEPTH-1];
    logic [31:0]       r_q_instr [0:QDEPTH-1];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    // Head-of-queue output registers
    logic              r_valid;
    logic [31:0]       r_head_pc;
    logic [31:0]       r_head_instr;

    // Combinational helpers
    logic [ADDR_W-1:0] w_idx0;
    logic [ADDR_W-1:0] w_idx1;
    logic [ADDR_W-1:0] w_idx2;
    logic [ADDR_W-1:0] w_idx3;
    logic [31:0]       w_rom_word;
    logic              w_pop;
    logic              w_push;
    logic [31:0]       w_target_aligned;
    logic [CW-1:0]     w_cnt_after_pop;
    logic [PW-1:0]     w_rd_after_pop;
    logic [CW-1:0]     w_count_nxt;
    logic [PW-1:0]     w_rd_nxt;
    logic [PW-1:0]     w_wr_nxt;
    logic [31:0]       w_head_pc_nxt;
    logic [31:0]       w_head_instr_nxt;

    // Combinational ROM read; each byte offset wraps within the ROM
    always_comb begin
        w_idx0     = r_pc[ADDR_W-1:0];
        w_idx1     = w_idx0 + ADDR_W'(1);
        w_idx2     = w_idx0 + ADDR_W'(2);
        w_idx3     = w_idx0 + ADDR_W'(3);
        w_rom_word = {Mem[w_idx0], Mem[w_idx1], Mem[w_idx2], Mem[w_idx3]};
    end

    // Handshake decode and next queue state
    always_comb begin
        w_pop            = r_valid & ready_in;
        w_push           = ~redirect_valid & ((r_count != FULL_CNT) | w_pop);
        w_target_aligned = {redirect_target[31:2], 2'b00};

        if (w_pop) begin
            w_cnt_after_pop = r_count - CW'(1);
            w_rd_after_pop  = r_rd_ptr + PW'(1);
        end else begin
            w_cnt_after_pop = r_count;
            w_rd_after_pop  = r_rd_ptr;
        end

        w_count_nxt      = r_count;
        w_rd_nxt         = r_rd_ptr;
        w_wr_nxt         = r_wr_ptr;
        w_head_pc_nxt    = r_head_pc;
        w_head_instr_nxt = r_head_instr;

        if (redirect_valid) begin
            // Any pop completes; everything left behind is flushed
            w_count_nxt = {CW{1'b0}};
            w_rd_nxt    = {PW{1'b0}};
            w_wr_nxt    = {PW{1'b0}};
        end else begin
            w_rd_nxt = w_rd_after_pop;
            if (w_push) begin
                w_count_nxt = w_cnt_after_pop + CW'(1);
                w_wr_nxt    = r_wr_ptr + PW'(1);
            end else begin
                w_count_nxt = w_cnt_after_pop;
                w_wr_nxt    = r_wr_ptr;
            end
            // The next head is either an already-queued entry or the word fetched now
            if (w_cnt_after_pop != {CW{1'b0}}) begin
                w_head_pc_nxt    = r_q_pc[w_rd_after_pop];
                w_head_instr_nxt = r_q_instr[w_rd_after_pop];
            end else if (w_push) begin
                w_head_pc_nxt    = r_pc;
                w_head_instr_nxt = w_rom_word;
            end else begin
                w_head_pc_nxt    = r_head_pc;
                w_head_instr_nxt = r_head_instr;
            end
        end
    end

    // PC/nPC update: redirect loads the aligned target, a push advances sequentially
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= RESET_PC;
            r_npc <= RESET_PC + 32'd4;
        end else if (redirect_valid) begin
            r_pc  <= w_target_aligned;
            r_npc <= w_target_aligned + 32'd4;
        end else if (w_push) begin
            r_pc  <= r_npc;
            r_npc <= r_npc + 32'd4;
        end
    end

    // Queue storage write at the write pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_pc[i]    <= 32'd0;
                r_q_instr[i] <= 32'd0;
            end
        end else if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_pc;
            r_q_instr[r_wr_ptr] <= w_rom_word;
        end
    end

    // Queue pointers, occupancy and registered head outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= {PW{1'b0}};
            r_rd_ptr     <= {PW{1'b0}};
            r_count      <= {CW{1'b0}};
            r_valid      <= 1'b0;
            r_head_pc    <= 32'd0;
            r_head_instr <= 32'd0;
        end else begin
            r_wr_ptr     <= w_wr_nxt;
            r_rd_ptr     <= w_rd_nxt;
            r_count      <= w_count_nxt;
            r_valid      <= (w_count_nxt != {CW{1'b0}});
            r_head_pc    <= w_head_pc_nxt;
            r_head_instr <= w_head_instr_nxt;
        end
    end

    assign valid_out = r_valid;
    assign instr_out = r_head_instr;
    assign pc_out    = r_head_pc;

`ifdef ALIGN_CHECK_EN
    logic r_misalign;

    // Sticky flag for redirects whose target is not word aligned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign_err = r_misalign;
`else
    logic w_tgt_low_unused;
    assign w_tgt_low_unused = ^redirect_target[1:0];
    assign misalign_err     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue_pnpc.sv
// Testbench for fetch_queue_pnpc: a vector table covering stall, redirect,
// wrap and misalign behaviour, plus hand-written reset sequences and a
// random-handshake scoreboard run.
module tb_fetch_queue_pnpc;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        misalign_err;

`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    fetch_queue_pnpc #(.ADDR_W(9), .QDEPTH(4), .RESET_PC(32'd0)) dut (
        .clk             (clk),
        .reset           (reset),
        .ready_in        (ready_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .valid_out       (valid_out),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_model [0:511];

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    logic        mis_exp;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [8:0] i;
        i = a[8:0];
        return {mem_model[i], mem_model[i + 9'd1], mem_model[i + 9'd2], mem_model[i + 9'd3]};
    endfunction

    function automatic vec_t mkv(input logic rdy, input logic rv, input logic [31:0] tgt,
                                 input logic ev, input logic [31:0] epc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.tgt = tgt; v.ev = ev; v.epc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold reset low for one cycle; release at a negedge with the given ready
    task automatic do_reset(input logic rdy);
        @(negedge clk);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        ready_in       = rdy;
        @(negedge clk);
        reset   = 1'b1;
        mis_exp = 1'b0;
    endtask

    initial begin
        reset           = 1'b0;
        ready_in        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        mis_exp         = 1'b0;

        for (int i = 0; i < 512; i++) mem_model[i] = 8'($urandom);
        mem_model[0] = 8'h24; mem_model[1] = 8'h01; mem_model[2] = 8'h00; mem_model[3] = 8'h05;
        mem_model[4] = 8'h00; mem_model[5] = 8'h22; mem_model[6] = 8'h18; mem_model[7] = 8'h23;
        for (int i = 0; i < 512; i++) dut.Mem[i] = mem_model[i];

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);

        // Basic latency and first two words
        reset = 1'b1;
        @(negedge clk);
        check("c1_valid", {31'd0, valid_out}, 32'd1);
        check("c1_pc", pc_out, 32'd0);
        check("c1_instr", instr_out, 32'h24010005);
        @(negedge clk);
        check("c2_pc", pc_out, 32'd4);
        check("c2_instr", instr_out, 32'h00221823);

        // Vector table: stall/saturate, release, redirects, wrap-around
        for (int k = 0; k < 6; k++) vecs.push_back(mkv(1'b0, 1'b0, 32'd0, 1'b1, 32'd0));
        vecs.push_back(mkv(1'b1, 1'b0, 32'd0, 1'b1, 32'd4));
        vecs.push_back(mkv(1'b1, 1'b0, 32'd0, 1'b1, 32'd8));
        vecs.push_back(mkv(1'b1, 1'b0, 32'd0, 1'b1, 32'd12));
        vecs.push_back(mkv(1'b1, 1'b0, 32'd0, 1'b1, 32'd16));
        vecs.push_back(mkv(1'b1, 1'b0, 32'd0, 1'b1, 32'd20));
        vecs.push_back(mkv(1'b0, 1'b1, 32'h40, 1'b0, 32'd0));
        vecs.push_back(mkv(1'b1, 1'b0, 32'd0, 1'b1, 32'h40));
        vecs.push_back(mkv(1'b1, 1'b0, 32'd0, 1'b1, 32'h44));
        vecs.push_back(mkv(1'b1, 1'b1, 32'h42, 1'b0, 32'd0));
        vecs.push_back(mkv(1'b1, 1'b0, 32'd0, 1'b1, 32'h40));
        vecs.push_back(mkv(1'b1, 1'b1, 32'h100, 1'b0, 32'd0));
        vecs.push_back(mkv(1'b1, 1'b1, 32'h1F8, 1'b0, 32'd0));
        vecs.push_back(mkv(1'b1, 1'b0, 32'd0, 1'b1, 32'h1F8));
        vecs.push_back(mkv(1'b1, 1'b0, 32'd0, 1'b1, 32'h1FC));
        vecs.push_back(mkv(1'b1, 1'b0, 32'd0, 1'b1, 32'h200));
        vecs.push_back(mkv(1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'd0));
        vecs.push_back(mkv(1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFC));
        vecs.push_back(mkv(1'b1, 1'b0, 32'd0, 1'b1, 32'h0));

        do_reset(1'b0);
        for (int k = 0; k < vecs.size(); k++) begin
            ready_in        = vecs[k].rdy;
            redirect_valid  = vecs[k].rv;
            redirect_target = vecs[k].tgt;
            if (ALIGN_EN && vecs[k].rv && (vecs[k].tgt[1:0] != 2'b00)) mis_exp = 1'b1;
            @(posedge clk);
            @(negedge clk);
            redirect_valid = 1'b0;
            check($sformatf("vec%0d_valid", k), {31'd0, valid_out}, {31'd0, vecs[k].ev});
            if (vecs[k].ev) begin
                check($sformatf("vec%0d_pc", k), pc_out, vecs[k].epc);
                check($sformatf("vec%0d_instr", k), instr_out, rom_word(vecs[k].epc));
            end
            check($sformatf("vec%0d_misalign", k), {31'd0, misalign_err}, {31'd0, mis_exp});
        end

        // Asynchronous reset mid-stream with two entries queued
        do_reset(1'b0);
        repeat (2) @(negedge clk);
        check("pre_areset_valid", {31'd0, valid_out}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("areset_valid", {31'd0, valid_out}, 32'd0);
        check("areset_pc", pc_out, 32'd0);
        check("areset_instr", instr_out, 32'd0);
        check("areset_misalign", {31'd0, misalign_err}, 32'd0);
        @(negedge clk);
        ready_in = 1'b1;
        reset    = 1'b1;
        mis_exp  = 1'b0;
        @(negedge clk);
        check("restart_valid", {31'd0, valid_out}, 32'd1);
        check("restart_pc", pc_out, 32'd0);
        check("restart_instr", instr_out, 32'h24010005);

        // Scoreboard run with random stalls and occasional redirects
        begin
            logic [31:0] last_pc;
            logic [31:0] prev_pc;
            logic        prev_stall;
            int          consumed;
            int          cyc;
            do_reset(1'b1);
            exp_q.delete();
            for (int k = 0; k < 16; k++) exp_q.push_back(32'(4 * k));
            last_pc    = 32'(4 * 15);
            prev_stall = 1'b0;
            prev_pc    = 32'd0;
            consumed   = 0;
            cyc        = 0;
            while (consumed < 150 && cyc < 2000) begin
                logic rdy;
                logic rv;
                logic [31:0] tgt;
                @(negedge clk);
                cyc++;
                check("sb_misalign", {31'd0, misalign_err}, {31'd0, mis_exp});
                if (prev_stall) begin
                    check("sb_hold_valid", {31'd0, valid_out}, 32'd1);
                    check("sb_hold_pc", pc_out, prev_pc);
                end
                rdy = ($urandom_range(0, 3) != 0);
                rv  = ($urandom_range(0, 19) == 0);
                tgt = $urandom;
                ready_in        = rdy;
                redirect_valid  = rv;
                redirect_target = tgt;
                if (valid_out && rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_underflow: got pc %h with no expected entry", pc_out);
                    end else begin
                        check("sb_pc", pc_out, exp_q[0]);
                        check("sb_instr", instr_out, rom_word(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                    consumed++;
                end
                prev_stall = valid_out && !rdy && !rv;
                prev_pc    = pc_out;
                if (rv) begin
                    exp_q.delete();
                    last_pc = {tgt[31:2], 2'b00};
                    exp_q.push_back(last_pc);
                    if (ALIGN_EN && (tgt[1:0] != 2'b00)) mis_exp = 1'b1;
                end
                while (exp_q.size() < 8) begin
                    last_pc = last_pc + 32'd4;
                    exp_q.push_back(last_pc);
                end
            end
            checks++;
            if (consumed < 150) begin
                failures++;
                $display("FAIL sb_progress: got %0d transfers expected 150", consumed);
            end
            redirect_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
